lm32_trace_buffer: RTL
======================

LM32_TRACE_BUFFER -- requirements
Module: lm32_trace_buffer

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of the number of trace entries (DEPTH = 2**DEPTH_LOG2).
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 stall_x  input  1  X-stage stall from pipeline.
REQ-005 stall_m  input  1  M-stage stall from pipeline.
REQ-006 valid_w  input  1  W-stage instruction valid.
REQ-007 kill_w  input  1  W-stage instruction killed.
REQ-008 instruction_d  input  32  instruction in D stage.
REQ-009 pc_w  input  30  word PC of W-stage instruction (byte address = pc_w<<2).
REQ-010 enable_i  input  1  capture enable.
REQ-011 clear_i  input  1  synchronous flush.
REQ-012 rd_ready_i  input  1  consumer accepts head entry.
REQ-013 rd_valid_o  output  1  head entry available.
REQ-014 rd_pc_o  output  30  PC of head entry.
REQ-015 rd_instr_o  output  32  instruction word of head entry.
REQ-016 count_o  output  DEPTH_LOG2+1  current occupancy.
REQ-017 overflow_o  output  1  sticky: at least one retire dropped while full.
REQ-018 drop_count_o  output  16  number of dropped retires, saturating at 0xFFFF.

Function
REQ-019 Instruction tracking SHALL be a 3-register shadow pipeline: instr_x <= instruction_d when !stall_x; instr_m <= instr_x when !stall_m; instr_w <= instr_m every cycle.
REQ-020 A retire event SHALL be valid_w && !kill_w && enable_i && pass_filter (pass_filter = 1 unless REQ-031 applies).
REQ-021 On a retire event with the buffer not full, {pc_w, instr_w} SHALL be written at the write pointer, and the write pointer and count SHALL advance in the same cycle.
REQ-022 On a retire event with the buffer full and no pop that cycle, the entry SHALL be dropped, overflow_o SHALL set, and drop_count_o SHALL increment unless it is already 0xFFFF.
REQ-023 rd_valid_o SHALL be 1 iff count_o != 0; rd_pc_o/rd_instr_o SHALL present the head entry combinationally (show-ahead, zero latency).
REQ-024 Pop SHALL occur when rd_valid_o && rd_ready_i; the read pointer advances and the next entry is visible the following cycle.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; when full, a simultaneous pop SHALL make room so the push is accepted (no drop).
REQ-026 A push into an empty buffer SHALL make rd_valid_o 1 on the next cycle (first-word latency 1 clock after the retire edge).
REQ-027 Pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-028 clear_i SHALL empty the buffer and clear overflow_o and drop_count_o; clear SHALL take priority over a same-cycle push and pop (both are discarded).
REQ-029 rd_ready_i while rd_valid_o = 0 SHALL have no effect.

Reset
REQ-030 On rst_n_i low, asynchronously: pointers = 0, count_o = 0, rd_valid_o = 0, overflow_o = 0, drop_count_o = 0, instr_x/m/w = 0; storage contents are not reset, and rd_pc_o/rd_instr_o are don't-care while rd_valid_o = 0. Reset asserted mid-operation SHALL discard all entries.

Configuration
REQ-031 With macro LM32_TRACE_FILTER_BRANCH_EN defined, pass_filter SHALL be 1 only for control-flow opcodes instr_w[31:26] in {0x11,0x12,0x13,0x14,0x15,0x17,0x2b,0x30,0x36,0x38,0x3e}; without it, pass_filter SHALL be constant 1 and every non-killed retire is captured.

Verification
REQ-032 Reset, then retire 3 instructions (pc_w 0x100..0x102, no stalls) with rd_ready_i = 0 -> count_o = 3; popping returns PCs 0x100, 0x101, 0x102 in order, with matching instructions delayed 3 stages from D.
REQ-033 DEPTH_LOG2 = 2, retire 6 with no reads -> count_o = 4, overflow_o = 1, drop_count_o = 2; the first 4 PCs are read back.
REQ-034 Full buffer, retire with rd_ready_i = 1 in the same cycle -> no drop, count_o stays 4, drop_count_o unchanged.
REQ-035 kill_w = 1 or enable_i = 0 on a retire -> no capture; stall_x held for 2 cycles -> the captured instruction matches the stalled D-stage word.
REQ-036 clear_i coincident with push and pop -> count_o = 0, overflow_o = 0, drop_count_o = 0 next cycle; rst_n_i asserted mid-stream -> rd_valid_o = 0 immediately.
REQ-037 With LM32_TRACE_FILTER_BRANCH_EN, retire sequence addi (0x0d), be (0x11), add (0x2d), calli (0x3e) -> only be and calli are captured (count_o = 2).

Source files
------------

// File: rtl/lm32_trace_buffer.sv
// lm32_trace_buffer
//   Captures retired LM32 instructions (word PC + instruction word) into a
//   small FIFO that a debug consumer drains through a show-ahead interface.
//   The instruction word travels alongside the pipeline in a three-register
//   shadow (X, M, W), so that it lines up with pc_w when the instruction
//   retires.
//
//   Build option: define LM32_TRACE_FILTER_BRANCH_EN to capture only
//   control-flow instructions. If it is not defined, every retire that is
//   valid, not killed and enabled is captured.
//
// Ports
//   clk_i, rst_n_i      clock; asynchronous active-low reset
//   stall_x, stall_m    pipeline stalls that hold the X/M shadow registers
//   valid_w, kill_w     W-stage retire qualifiers
//   instruction_d       D-stage instruction word entering the shadow pipe
//   pc_w                word PC of the W-stage instruction
//   enable_i            capture enable
//   clear_i             synchronous flush of entries and overflow state
//   rd_ready_i          consumer accepts the head entry
//   rd_valid_o          head entry present
//   rd_pc_o, rd_instr_o head entry (combinational, zero latency)
//   count_o             occupancy, 0..DEPTH
//   overflow_o          sticky flag: a retire was dropped because the buffer was full
//   drop_count_o        number of dropped retires, saturating at 0xFFFF

module lm32_trace_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_x,
    input  logic                  stall_m,
    input  logic                  valid_w,
    input  logic                  kill_w,
    input  logic [31:0]           instruction_d,
    input  logic [29:0]           pc_w,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [29:0]           rd_pc_o,
    output logic [31:0]           rd_instr_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_count_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [31:0] instr_x_q, instr_m_q, instr_w_q;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [29:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic pass_filter;
    logic retire;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    // Shadow of the instruction word; W advances unconditionally because
    // the W stage never stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_x_q <= '0;
            instr_m_q <= '0;
            instr_w_q <= '0;
        end else begin
            if (!stall_x) instr_x_q <= instruction_d;
            if (!stall_m) instr_m_q <= instr_x_q;
            instr_w_q <= instr_m_q;
        end
    end

`ifdef LM32_TRACE_FILTER_BRANCH_EN
    // Branch, call, return and exception-entry opcodes.
    always_comb begin
        pass_filter = 1'b0;
        case (instr_w_q[31:26])
            6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h17,
            6'h2b, 6'h30, 6'h36, 6'h38, 6'h3e: pass_filter = 1'b1;
            default:                           pass_filter = 1'b0;
        endcase
    end
`else
    assign pass_filter = 1'b1;
`endif

    assign retire = valid_w && !kill_w && enable_i && pass_filter;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // Clear discards any push or pop in the same cycle. A pop frees a slot
    // in time for a push in the same cycle, so a full buffer that is being
    // read does not drop the retire.
    assign pop  = !empty && rd_ready_i && !clear_i;
    assign push = retire && (!full || pop) && !clear_i;
    assign drop = retire && full && !pop && !clear_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q[DEPTH_LOG2-1:0]]    <= pc_w;
            instr_mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= instr_w_q;
        end
    end

    assign rd_valid_o   = !empty;
    assign rd_pc_o      = pc_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign rd_instr_o   = instr_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign count_o      = wr_ptr_q - rd_ptr_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule
